// File: rtl/vga_line_fetch.sv
// VGA line fetch: prefetches framebuffer pixels in linear order into a small FIFO
// and hands them to the timing generator one per PIX_REQ, with a sticky underrun flag.
module vga_line_fetch #(
    parameter int unsigned H_PIXELS   = 800,
    parameter int unsigned V_LINES    = 600,
    parameter int unsigned DATA_W     = 12,
    parameter int unsigned ADDR_W     = 19,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic              VGA_CLK,
    input  logic              VGA_RST_N,
    input  logic              FRAME_START,
    input  logic              PIX_REQ,
    output logic [DATA_W-1:0] PIX_DATA,
    output logic              PIX_VALID,
    output logic              FB_RD_EN,
    output logic [ADDR_W-1:0] FB_ADDR,
    input  logic [DATA_W-1:0] FB_DATA,
    output logic              UNDERRUN
);

    localparam int unsigned       PtrW     = $clog2(FIFO_DEPTH);
    localparam int unsigned       CntW     = PtrW + 1;
    localparam logic [CntW-1:0]   DepthC   = CntW'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(H_PIXELS * V_LINES - 1);

    typedef enum logic [1:0] {StIdle, StFetch, StDone} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]   count_q, count_d;
    logic              inflight_q;
    logic [DATA_W-1:0] pix_data_q;
    logic              pix_valid_q;
    logic              underrun_q;

    logic              rd_en;
    logic              last_rd;
    logic              fifo_wr;
    logic              fifo_pop;
    logic              underrun_set;
    logic [CntW-1:0]   occupancy;

    // FRAME_START overrides everything: no write of returning data, no pop, no underrun.
    assign fifo_wr      = inflight_q & ~FRAME_START;
    assign fifo_pop     = PIX_REQ & ~FRAME_START & (count_q != '0);
    assign underrun_set = PIX_REQ & ~FRAME_START & (count_q == '0);
    assign occupancy    = count_q + CntW'(inflight_q);

    // State register.
    always_ff @(posedge VGA_CLK or negedge VGA_RST_N) begin
        if (!VGA_RST_N) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: fetch runs from FRAME_START until the last address of the frame is issued.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (FRAME_START) state_d = StFetch;
            StFetch: if (last_rd)     state_d = StDone;
            StDone:  if (FRAME_START) state_d = StFetch;
            default: state_d = StIdle;
        endcase
    end

    // Read strobe: only while fetching, never in a FRAME_START cycle, and only if the
    // FIFO has room for this read on top of what is stored and already in flight.
    always_comb begin
        rd_en = 1'b0;
        if (state_q == StFetch && !FRAME_START && occupancy < DepthC) begin
            rd_en = 1'b1;
        end
        last_rd = rd_en & (addr_q == LastAddr);
    end

    // Address counter and occupancy next-state; the counter parks on the last address.
    always_comb begin
        addr_d  = addr_q;
        count_d = count_q + CntW'(fifo_wr) - CntW'(fifo_pop);
        if (FRAME_START) begin
            addr_d  = '0;
            count_d = '0;
        end else if (rd_en && !last_rd) begin
            addr_d = addr_q + ADDR_W'(1);
        end
    end

    // Datapath registers: counters, pointers, in-flight marker and pixel output stage.
    always_ff @(posedge VGA_CLK or negedge VGA_RST_N) begin
        if (!VGA_RST_N) begin
            addr_q      <= '0;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            inflight_q  <= 1'b0;
            pix_data_q  <= '0;
            pix_valid_q <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            addr_q      <= addr_d;
            count_q     <= count_d;
            inflight_q  <= rd_en;
            pix_valid_q <= fifo_pop;
            pix_data_q  <= fifo_pop ? mem_q[rd_ptr_q] : '0;
            if (FRAME_START) begin
                wr_ptr_q   <= '0;
                rd_ptr_q   <= '0;
                underrun_q <= 1'b0;
            end else begin
                wr_ptr_q <= wr_ptr_q + PtrW'(fifo_wr);
                rd_ptr_q <= rd_ptr_q + PtrW'(fifo_pop);
                if (underrun_set) underrun_q <= 1'b1;
            end
        end
    end

    // FIFO storage; a pop only sees entries written in earlier cycles (no bypass).
    always_ff @(posedge VGA_CLK) begin
        if (fifo_wr) mem_q[wr_ptr_q] <= FB_DATA;
    end

    assign FB_RD_EN  = rd_en;
    assign FB_ADDR   = addr_q;
    assign PIX_DATA  = pix_data_q;
    assign PIX_VALID = pix_valid_q;
    assign UNDERRUN  = underrun_q;

endmodule

// File: tb/tb_vga_line_fetch.sv
// Self-checking bench for vga_line_fetch: framebuffer returns data = address, and a
// queue-based model of the pixel stream predicts PIX_DATA/PIX_VALID/UNDERRUN.
module tb_vga_line_fetch;

    // Frame height shortened so a complete frame fits in a short run.
    localparam int unsigned H_PIXELS   = 800;
    localparam int unsigned V_LINES    = 48;
    localparam int unsigned DATA_W     = 12;
    localparam int unsigned ADDR_W     = 19;
    localparam int unsigned FIFO_DEPTH = 16;
    localparam int          FRAME_PIX  = H_PIXELS * V_LINES;

    logic              VGA_CLK;
    logic              VGA_RST_N;
    logic              FRAME_START;
    logic              PIX_REQ;
    logic [DATA_W-1:0] PIX_DATA;
    logic              PIX_VALID;
    logic              FB_RD_EN;
    logic [ADDR_W-1:0] FB_ADDR;
    logic [DATA_W-1:0] FB_DATA;
    logic              UNDERRUN;

    vga_line_fetch #(
        .H_PIXELS  (H_PIXELS),
        .V_LINES   (V_LINES),
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .VGA_CLK    (VGA_CLK),
        .VGA_RST_N  (VGA_RST_N),
        .FRAME_START(FRAME_START),
        .PIX_REQ    (PIX_REQ),
        .PIX_DATA   (PIX_DATA),
        .PIX_VALID  (PIX_VALID),
        .FB_RD_EN   (FB_RD_EN),
        .FB_ADDR    (FB_ADDR),
        .FB_DATA    (FB_DATA),
        .UNDERRUN   (UNDERRUN)
    );

    initial VGA_CLK = 1'b0;
    always #5 VGA_CLK = ~VGA_CLK;

    // Framebuffer: data = address, one cycle after the strobe; junk otherwise.
    always @(posedge VGA_CLK) begin
        FB_DATA <= FB_RD_EN ? FB_ADDR[DATA_W-1:0] : DATA_W'($urandom);
    end

    int checks   = 0;
    int failures = 0;

    // Reference model: the FIFO is just the ordered list of fetched, unpopped pixels.
    logic [DATA_W-1:0] m_fifo[$];
    bit                m_pend;
    logic [DATA_W-1:0] m_pend_data;
    int                m_next_addr;
    bit                m_fetching;
    bit                m_valid;
    logic [DATA_W-1:0] m_data;
    bit                m_under;

    // Values seen just before the last active edge.
    bit s_rd;
    int s_addr;
    bit s_allowed;
    int s_exp_addr;

    task automatic model_reset();
        m_fifo.delete();
        m_pend      = 1'b0;
        m_pend_data = '0;
        m_next_addr = 0;
        m_fetching  = 1'b0;
        m_valid     = 1'b0;
        m_data      = '0;
        m_under     = 1'b0;
    endtask

    // One clock: drive inputs at the falling edge, sample the read bus, advance the model
    // on the rising edge, return at the next falling edge.
    task automatic cycle(input bit fs, input bit req);
        FRAME_START = fs;
        PIX_REQ     = req;
        #1;
        s_rd       = FB_RD_EN;
        s_addr     = int'(FB_ADDR);
        s_allowed  = m_fetching && !fs && (m_fifo.size() + int'(m_pend) < int'(FIFO_DEPTH));
        s_exp_addr = m_next_addr;
        @(posedge VGA_CLK);
        if (fs) begin
            model_reset();
            m_fetching = 1'b1;
        end else begin
            if (req && m_fifo.size() > 0) begin
                m_data  = m_fifo.pop_front();
                m_valid = 1'b1;
            end else begin
                m_data  = '0;
                m_valid = 1'b0;
                if (req) m_under = 1'b1;
            end
            if (m_pend) m_fifo.push_back(m_pend_data);
            m_pend      = s_rd;
            m_pend_data = DATA_W'(m_next_addr);
            if (s_rd) begin
                if (m_next_addr == FRAME_PIX - 1) m_fetching = 1'b0;
                else m_next_addr++;
            end
        end
        @(negedge VGA_CLK);
    endtask

    task automatic test_reset();
        VGA_RST_N   = 1'b0;
        FRAME_START = 1'b0;
        PIX_REQ     = 1'b0;
        model_reset();
        repeat (3) @(negedge VGA_CLK);
        checks++; if (PIX_DATA !== '0) begin failures++;
            $display("FAIL reset_pix_data: got %0h want 0", PIX_DATA); end
        checks++; if (PIX_VALID !== 1'b0) begin failures++;
            $display("FAIL reset_pix_valid: got %0b want 0", PIX_VALID); end
        checks++; if (FB_RD_EN !== 1'b0) begin failures++;
            $display("FAIL reset_fb_rd_en: got %0b want 0", FB_RD_EN); end
        checks++; if (FB_ADDR !== '0) begin failures++;
            $display("FAIL reset_fb_addr: got %0d want 0", FB_ADDR); end
        checks++; if (UNDERRUN !== 1'b0) begin failures++;
            $display("FAIL reset_underrun: got %0b want 0", UNDERRUN); end
        #2 VGA_RST_N = 1'b1;
        @(negedge VGA_CLK);
        cycle(1'b0, 1'b0);
        checks++; if (s_rd !== 1'b0) begin failures++;
            $display("FAIL reset_exit_read: got %0b want 0", s_rd); end
    endtask

    // Request in IDLE underruns; a FRAME_START coinciding with a request clears it instead.
    task automatic test_idle_underrun();
        cycle(1'b0, 1'b1);
        checks++; if (PIX_VALID !== 1'b0) begin failures++;
            $display("FAIL idle_req_valid: got %0b want 0", PIX_VALID); end
        checks++; if (PIX_DATA !== '0) begin failures++;
            $display("FAIL idle_req_data: got %0h want 0", PIX_DATA); end
        checks++; if (UNDERRUN !== 1'b1) begin failures++;
            $display("FAIL idle_underrun_set: got %0b want 1", UNDERRUN); end
        cycle(1'b1, 1'b1);
        checks++; if (UNDERRUN !== 1'b0) begin failures++;
            $display("FAIL fs_clears_underrun: got %0b want 0", UNDERRUN); end
        checks++; if (PIX_VALID !== 1'b0) begin failures++;
            $display("FAIL fs_wins_valid: got %0b want 0", PIX_VALID); end
        checks++; if (s_rd !== 1'b0) begin failures++;
            $display("FAIL fs_cycle_read: got %0b want 0", s_rd); end
    endtask

    // With no requests the fetcher issues 0..15 back to back, then stops with a full FIFO.
    task automatic test_prefetch();
        int reads = 0;
        for (int i = 0; i < 25; i++) begin
            cycle(1'b0, 1'b0);
            checks++; if (s_rd !== (i < int'(FIFO_DEPTH))) begin failures++;
                $display("FAIL prefetch_rd_en[%0d]: got %0b want %0b", i, s_rd,
                         (i < int'(FIFO_DEPTH))); end
            if (s_rd) begin
                checks++; if (s_addr !== i) begin failures++;
                    $display("FAIL prefetch_addr[%0d]: got %0d want %0d", i, s_addr, i); end
                reads++;
            end
        end
        checks++; if (reads !== int'(FIFO_DEPTH)) begin failures++;
            $display("FAIL prefetch_count: got %0d want %0d", reads, FIFO_DEPTH); end
        checks++; if (m_fifo.size() !== int'(FIFO_DEPTH)) begin failures++;
            $display("FAIL prefetch_fill: got %0d want %0d", m_fifo.size(), FIFO_DEPTH); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < int'(H_PIXELS); i++) begin
            cycle(1'b0, 1'b1);
            checks++; if (PIX_VALID !== 1'b1 || PIX_DATA !== DATA_W'(i)) begin failures++;
                $display("FAIL b2b_pixel[%0d]: got v=%0b d=%0d want v=1 d=%0d", i, PIX_VALID,
                         PIX_DATA, i); end
            checks++; if (UNDERRUN !== 1'b0) begin failures++;
                $display("FAIL b2b_underrun[%0d]: got %0b want 0", i, UNDERRUN); end
            checks++; if (s_rd && (!s_allowed || s_addr != s_exp_addr)) begin failures++;
                $display("FAIL b2b_read[%0d]: got addr %0d want %0d allowed %0b", i, s_addr,
                         s_exp_addr, s_allowed); end
        end
        cycle(1'b0, 1'b0);
        checks++; if (PIX_VALID !== 1'b0 || PIX_DATA !== '0) begin failures++;
            $display("FAIL blank_output: got v=%0b d=%0h want v=0 d=0", PIX_VALID, PIX_DATA); end
    endtask

    // FRAME_START right after the read of address 37: its data must not reach the FIFO.
    task automatic test_discard();
        bit found = 1'b0;
        cycle(1'b1, 1'b0);
        repeat (20) cycle(1'b0, 1'b0);
        for (int k = 0; k < 200 && !found; k++) begin
            cycle(1'b0, 1'b1);
            if (s_rd && s_addr == 37) found = 1'b1;
        end
        checks++; if (!found) begin failures++;
            $display("FAIL discard_wait37: got no read of 37 want read of 37"); end
        cycle(1'b1, 1'b1);
        checks++; if (PIX_VALID !== 1'b0 || UNDERRUN !== 1'b0) begin failures++;
            $display("FAIL discard_fs: got v=%0b u=%0b want v=0 u=0", PIX_VALID, UNDERRUN); end
        cycle(1'b0, 1'b0);
        checks++; if (s_rd !== 1'b1 || s_addr !== 0) begin failures++;
            $display("FAIL discard_restart: got rd=%0b addr=%0d want rd=1 addr=0", s_rd,
                     s_addr); end
        repeat (5) cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b1);
        checks++; if (PIX_VALID !== 1'b1 || PIX_DATA !== '0) begin failures++;
            $display("FAIL discard_first_pixel: got v=%0b d=%0d want v=1 d=0", PIX_VALID,
                     PIX_DATA); end
    endtask

    task automatic test_full_frame();
        int last_addr = -1;
        int late_reads = 0;
        logic [DATA_W-1:0] last_pix;
        cycle(1'b1, 1'b0);
        repeat (20) begin
            cycle(1'b0, 1'b0);
            if (s_rd) last_addr = s_addr;
        end
        for (int i = 0; i < FRAME_PIX; i++) begin
            cycle(1'b0, 1'b1);
            if (s_rd) last_addr = s_addr;
            checks++; if (PIX_VALID !== 1'b1 || PIX_DATA !== DATA_W'(i)) begin failures++;
                $display("FAIL frame_pixel[%0d]: got v=%0b d=%0d want v=1 d=%0d", i, PIX_VALID,
                         PIX_DATA, DATA_W'(i)); end
        end
        last_pix = DATA_W'(FRAME_PIX - 1);
        checks++; if (PIX_DATA !== last_pix) begin failures++;
            $display("FAIL frame_last_pixel: got %0d want %0d", PIX_DATA, last_pix); end
        checks++; if (last_addr !== FRAME_PIX - 1) begin failures++;
            $display("FAIL frame_last_addr: got %0d want %0d", last_addr, FRAME_PIX - 1); end
        checks++; if (UNDERRUN !== 1'b0) begin failures++;
            $display("FAIL frame_underrun: got %0b want 0", UNDERRUN); end
        repeat (40) begin
            cycle(1'b0, 1'b0);
            if (s_rd) late_reads++;
        end
        checks++; if (late_reads !== 0) begin failures++;
            $display("FAIL frame_done_reads: got %0d want 0", late_reads); end
        cycle(1'b0, 1'b1);
        checks++; if (UNDERRUN !== 1'b1 || PIX_VALID !== 1'b0) begin failures++;
            $display("FAIL done_underrun: got u=%0b v=%0b want u=1 v=0", UNDERRUN,
                     PIX_VALID); end
    endtask

    task automatic test_random();
        int rate = 50;
        cycle(1'b1, 1'b0);
        for (int i = 0; i < 4000; i++) begin
            bit fs;
            bit req;
            if (i % 64 == 0) rate = int'($urandom_range(20, 100));
            fs  = ($urandom_range(0, 499) == 0);
            req = (int'($urandom_range(1, 100)) <= rate);
            cycle(fs, req);
            checks++; if (PIX_VALID !== m_valid || PIX_DATA !== m_data) begin failures++;
                $display("FAIL rand_pixel[%0d]: got v=%0b d=%0d want v=%0b d=%0d", i,
                         PIX_VALID, PIX_DATA, m_valid, m_data); end
            checks++; if (UNDERRUN !== m_under) begin failures++;
                $display("FAIL rand_underrun[%0d]: got %0b want %0b", i, UNDERRUN, m_under); end
            checks++; if (s_rd && (!s_allowed || s_addr != s_exp_addr)) begin failures++;
                $display("FAIL rand_read[%0d]: got addr %0d want %0d allowed %0b", i, s_addr,
                         s_exp_addr, s_allowed); end
        end
    endtask

    // Reset mid-frame between clock edges; outputs clear at once and fetch waits for a frame.
    task automatic test_async_reset();
        int stray = 0;
        cycle(1'b1, 1'b0);
        repeat (10) cycle(1'b0, 1'b0);
        repeat (10) cycle(1'b0, 1'b1);
        #($urandom_range(1, 3));
        VGA_RST_N = 1'b0;
        #1;
        checks++; if (PIX_DATA !== '0 || PIX_VALID !== 1'b0 || UNDERRUN !== 1'b0) begin
            failures++;
            $display("FAIL async_rst_pix: got d=%0h v=%0b u=%0b want 0", PIX_DATA, PIX_VALID,
                     UNDERRUN); end
        checks++; if (FB_RD_EN !== 1'b0 || FB_ADDR !== '0) begin failures++;
            $display("FAIL async_rst_fb: got rd=%0b addr=%0d want 0", FB_RD_EN, FB_ADDR); end
        @(negedge VGA_CLK);
        model_reset();
        #3 VGA_RST_N = 1'b1;
        @(negedge VGA_CLK);
        repeat (30) begin
            cycle(1'b0, 1'($urandom_range(0, 1)));
            if (s_rd) stray++;
        end
        checks++; if (stray !== 0) begin failures++;
            $display("FAIL async_rst_no_read: got %0d reads want 0", stray); end
        checks++; if (PIX_VALID !== 1'b0) begin failures++;
            $display("FAIL async_rst_valid: got %0b want 0", PIX_VALID); end
        cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b0);
        checks++; if (s_rd !== 1'b1 || s_addr !== 0) begin failures++;
            $display("FAIL async_rst_restart: got rd=%0b addr=%0d want rd=1 addr=0", s_rd,
                     s_addr); end
    endtask

    initial begin
        test_reset();
        test_idle_underrun();
        test_prefetch();
        test_back_to_back();
        test_discard();
        test_full_frame();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
